// File: rtl/mainbus_pkg.sv
// Shared main-bus definitions: select codes used by the stage-2 control
// decoder and by every device slot, plus the FIFO device status byte layout.
package mainbus_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [SEL_W-1:0] {
    SEL_NONE  = 4'd0,
    SEL_A     = 4'd1,
    SEL_B     = 4'd2,
    SEL_C     = 4'd3,
    SEL_D     = 4'd4,
    SEL_E     = 4'd5,
    SEL_F     = 4'd6,
    SEL_G     = 4'd7,
    SEL_ALU   = 4'd8,
    SEL_DEV9  = 4'd9,
    SEL_DEV10 = 4'd10,
    SEL_DEV11 = 4'd11,
    SEL_DEV12 = 4'd12,
    SEL_DEV13 = 4'd13,
    SEL_DEV14 = 4'd14,
    SEL_MEM   = 4'd15
  } sel_e;

  // Status byte: sticky flags in the top two bits, live FIFO levels below.
  function automatic logic [7:0] status_byte(input logic tx_ovf, input logic rx_unf,
                                             input logic tx_full, input logic tx_empty,
                                             input logic rx_full, input logic rx_empty);
    return {tx_ovf, rx_unf, 2'b00, tx_full, tx_empty, rx_full, rx_empty};
  endfunction

endpackage

// File: rtl/mainbus_fifo_device_if.sv
// Main-bus select/data signals and the external TX/RX byte streams of the
// FIFO device. The device uses the slave modport; the bus side uses master.
interface mainbus_fifo_device_if #(parameter int WIDTH = 8);
  import mainbus_pkg::*;

  logic [SEL_W-1:0] mainbus_assert_select;
  logic [SEL_W-1:0] mainbus_load_select;
  logic [WIDTH-1:0] mainbus_in;
  logic [WIDTH-1:0] mainbus_out;
  logic             mainbus_oe_n;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport slave (
    input  mainbus_assert_select, mainbus_load_select, mainbus_in,
    input  tx_ready, rx_data, rx_valid,
    output mainbus_out, mainbus_oe_n, tx_data, tx_valid, rx_ready
  );

  modport master (
    output mainbus_assert_select, mainbus_load_select, mainbus_in,
    output tx_ready, rx_data, rx_valid,
    input  mainbus_out, mainbus_oe_n, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/mainbus_fifo_device_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Push is ignored when full and
// pop when empty, so callers may qualify or not. Storage is not reset.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer values; each pointer advances independently.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  // Pointer registers, cleared asynchronously so contents are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write at the current write slot.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mainbus_fifo_device.sv
// Main-bus FIFO peripheral: CPU loads push into TX, CPU asserts pop from RX.
// Optional status port at STATUS_ID enabled by macro MAINBUS_FIFO_STATUS_EN.
module mainbus_fifo_device
  import mainbus_pkg::*;
#(
  parameter logic [SEL_W-1:0] DEV_ID    = SEL_DEV9,
  parameter logic [SEL_W-1:0] STATUS_ID = SEL_DEV10,
  parameter int               DEPTH     = 8,
  parameter int               WIDTH     = 8
) (
  input logic                  clk,
  input logic                  reset,
  mainbus_fifo_device_if.slave bus
);

  if (DEV_ID == STATUS_ID || DEV_ID < SEL_DEV9 || DEV_ID > SEL_DEV14 ||
      STATUS_ID < SEL_DEV9 || STATUS_ID > SEL_DEV14 ||
      DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mainbus_fifo_device: illegal DEV_ID/STATUS_ID/DEPTH");
  end

  logic             dev_wr, dev_rd, st_rd;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [WIDTH-1:0] tx_head, rx_head, status_w;

  // Decode is gated by reset so the bus outputs hold their idle values.
  assign dev_wr = !reset && (bus.mainbus_load_select == DEV_ID);
  assign dev_rd = !reset && (bus.mainbus_assert_select == DEV_ID);

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx (
    .clk(clk), .rst(reset),
    .push_i(dev_wr), .pop_i(bus.tx_ready), .data_i(bus.mainbus_in),
    .full_o(tx_full), .empty_o(tx_empty), .head_o(tx_head)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx (
    .clk(clk), .rst(reset),
    .push_i(bus.rx_valid), .pop_i(dev_rd), .data_i(bus.rx_data),
    .full_o(rx_full), .empty_o(rx_empty), .head_o(rx_head)
  );

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? '0 : tx_head;
  assign bus.rx_ready = !rx_full;

`ifdef MAINBUS_FIFO_STATUS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  assign st_rd = !reset && (bus.mainbus_assert_select == STATUS_ID);

  // Sticky flags: a status read clears them, but a new event that cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (st_rd) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (dev_wr && tx_full)  ovf_d = 1'b1;
    if (dev_rd && rx_empty) unf_d = 1'b1;
  end

  // Sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Status word, zero-extended above the defined byte.
  always_comb begin
    status_w      = '0;
    status_w[7:0] = status_byte(ovf_q, unf_q, tx_full, tx_empty, rx_full, rx_empty);
  end
`else
  assign st_rd    = 1'b0;
  assign status_w = '0;
`endif

  // Bus drive: RX head for a data read (zero when empty), status word otherwise.
  always_comb begin
    bus.mainbus_out  = '0;
    bus.mainbus_oe_n = !(dev_rd || st_rd);
    if (dev_rd) begin
      if (!rx_empty) bus.mainbus_out = rx_head;
    end else if (st_rd) begin
      bus.mainbus_out = status_w;
    end
  end

endmodule

// File: tb/tb_mainbus_fifo_device.sv
module tb_mainbus_fifo_device;
  import mainbus_pkg::*;

  localparam logic [3:0] DEV   = SEL_DEV9;
  localparam logic [3:0] ST    = SEL_DEV10;
  localparam int         DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mainbus_fifo_device_if #(.WIDTH(8)) bus();

  mainbus_fifo_device #(.DEV_ID(DEV), .STATUS_ID(ST), .DEPTH(DEPTH), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: two byte queues and two sticky flags.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       ovf = 1'b0;
  logic       unf = 1'b0;

  function automatic logic e_tx_valid();
    return txq.size() != 0;
  endfunction

  function automatic logic [7:0] e_tx_data();
    return (txq.size() != 0) ? txq[0] : 8'h00;
  endfunction

  function automatic logic e_rx_ready();
    return rxq.size() < DEPTH;
  endfunction

  function automatic logic e_oe_n();
    if (bus.mainbus_assert_select == DEV) return 1'b0;
`ifdef MAINBUS_FIFO_STATUS_EN
    if (bus.mainbus_assert_select == ST) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [7:0] e_out();
    if (bus.mainbus_assert_select == DEV) return (rxq.size() != 0) ? rxq[0] : 8'h00;
`ifdef MAINBUS_FIFO_STATUS_EN
    if (bus.mainbus_assert_select == ST)
      return {ovf, unf, 2'b00, txq.size() == DEPTH, txq.size() == 0,
              rxq.size() == DEPTH, rxq.size() == 0};
`endif
    return 8'h00;
  endfunction

  // Apply one cycle of inputs at the negedge, leaving time to observe outputs.
  task automatic drive(input logic [3:0] ld, input logic [3:0] as, input logic [7:0] din,
                       input logic trdy, input logic rv, input logic [7:0] rd);
    @(negedge clk);
    bus.mainbus_load_select   = ld;
    bus.mainbus_assert_select = as;
    bus.mainbus_in            = din;
    bus.tx_ready              = trdy;
    bus.rx_valid              = rv;
    bus.rx_data               = rd;
    #1;
  endtask

  // Commit the posedge and advance the model from the pre-edge state.
  task automatic step();
    int  txn, rxn;
    logic ld_dev, as_dev, as_st;
    @(posedge clk);
    txn    = txq.size();
    rxn    = rxq.size();
    ld_dev = (bus.mainbus_load_select == DEV);
    as_dev = (bus.mainbus_assert_select == DEV);
    as_st  = (bus.mainbus_assert_select == ST);
    if (as_st) begin
      ovf = 1'b0;
      unf = 1'b0;
    end
    if (txn > 0 && bus.tx_ready) void'(txq.pop_front());
    if (ld_dev) begin
      if (txn < DEPTH) txq.push_back(bus.mainbus_in);
      else ovf = 1'b1;
    end
    if (as_dev) begin
      if (rxn > 0) void'(rxq.pop_front());
      else unf = 1'b1;
    end
    if (bus.rx_valid && rxn < DEPTH) rxq.push_back(bus.rx_data);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
    checks++; if (bus.mainbus_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n: got %b want 1", bus.mainbus_oe_n); end
    checks++; if (bus.mainbus_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", bus.mainbus_out); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    reset = 1'b0;
  endtask

  task automatic test_tx_basic();
    logic [7:0] exp [3];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(DEV, SEL_NONE, exp[i], 1'b0, 1'b0, 8'h00);
      step();
    end
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL tx_basic_valid: got %b want 1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h11) begin errors++; $display("FAIL tx_basic_head: got %h want 11", bus.tx_data); end
    step();
    for (int i = 0; i < 3; i++) begin
      drive(SEL_NONE, SEL_NONE, 8'h00, 1'b1, 1'b0, 8'h00);
      checks++; if (bus.tx_data !== exp[i] || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL tx_basic_drain%0d: got %h/%b want %h/1", i, bus.tx_data, bus.tx_valid, exp[i]); end
      step();
    end
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_basic_empty: got %b want 0", bus.tx_valid); end
    step();
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      drive(DEV, SEL_NONE, 8'(i), 1'b0, 1'b0, 8'h00);
      step();
    end
    drive(DEV, SEL_NONE, 8'hAA, 1'b0, 1'b0, 8'h00);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(SEL_NONE, SEL_NONE, 8'h00, 1'b1, 1'b0, 8'h00);
      checks++; if (bus.tx_data !== 8'(i)) begin errors++; $display("FAIL tx_ovf_drain%0d: got %h want %h", i, bus.tx_data, 8'(i)); end
      step();
    end
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ovf_dropped: got valid %b want 0", bus.tx_valid); end
    step();
  endtask

  task automatic test_rx_read();
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b1, 8'h5C);
    step();
    drive(SEL_NONE, DEV, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_oe_n !== 1'b0) begin errors++; $display("FAIL rx_read_oe_n: got %b want 0", bus.mainbus_oe_n); end
    checks++; if (bus.mainbus_out !== 8'h5C) begin errors++; $display("FAIL rx_read_data: got %h want 5c", bus.mainbus_out); end
    step();
    drive(SEL_NONE, DEV, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_out !== 8'h00) begin errors++; $display("FAIL rx_underflow_data: got %h want 00", bus.mainbus_out); end
    step();
  endtask

  task automatic test_rx_full();
    logic [7:0] v [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      v[i] = 8'($urandom);
      drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b1, v[i]);
      step();
    end
    drive(SEL_NONE, DEV, 8'h00, 1'b0, 1'b1, 8'hEE);
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", bus.rx_ready); end
    checks++; if (bus.mainbus_out !== v[0]) begin errors++; $display("FAIL rx_full_head: got %h want %h", bus.mainbus_out, v[0]); end
    step();
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rx_full_ready_after: got %b want 1", bus.rx_ready); end
    step();
    for (int i = 1; i < DEPTH; i++) begin
      drive(SEL_NONE, DEV, 8'h00, 1'b0, 1'b0, 8'h00);
      checks++; if (bus.mainbus_out !== v[i]) begin errors++; $display("FAIL rx_full_drain%0d: got %h want %h", i, bus.mainbus_out, v[i]); end
      step();
    end
    drive(SEL_NONE, DEV, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_out !== 8'h00) begin errors++; $display("FAIL rx_full_count7: got %h want 00", bus.mainbus_out); end
    step();
  endtask

  task automatic test_status();
`ifdef MAINBUS_FIFO_STATUS_EN
    drive(SEL_NONE, ST, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_oe_n !== 1'b0) begin errors++; $display("FAIL status_oe_n: got %b want 0", bus.mainbus_oe_n); end
    checks++; if (bus.mainbus_out !== 8'hC5) begin errors++; $display("FAIL status_flags_set: got %h want c5", bus.mainbus_out); end
    step();
    drive(SEL_NONE, ST, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_out !== 8'h05) begin errors++; $display("FAIL status_flags_clear: got %h want 05", bus.mainbus_out); end
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(DEV, SEL_NONE, 8'(i + 16), 1'b0, 1'b0, 8'h00);
      step();
    end
    drive(DEV, ST, 8'hBB, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_out !== 8'h09) begin errors++; $display("FAIL status_tx_full: got %h want 09", bus.mainbus_out); end
    step();
    drive(SEL_NONE, ST, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_out !== 8'h89) begin errors++; $display("FAIL status_event_wins: got %h want 89", bus.mainbus_out); end
    step();
`else
    drive(ST, ST, 8'h42, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.mainbus_oe_n !== 1'b1) begin errors++; $display("FAIL status_absent_oe_n: got %b want 1", bus.mainbus_oe_n); end
    checks++; if (bus.mainbus_out !== 8'h00) begin errors++; $display("FAIL status_absent_out: got %h want 00", bus.mainbus_out); end
    step();
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL status_load_ignored: got valid %b want 0", bus.tx_valid); end
    step();
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(SEL_NONE, SEL_NONE, 8'h00, 1'b1, 1'b0, 8'h00);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(DEV, SEL_NONE, 8'hA1 + 8'(i), 1'b0, 1'b1, 8'h30 + 8'(i));
      step();
    end
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA1) begin errors++; $display("FAIL rst_pre: got %b/%h want 1/a1", bus.tx_valid, bus.tx_data); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async_tx_valid: got %b want 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_async_tx_data: got %h want 00", bus.tx_data); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL rst_async_rx_ready: got %b want 1", bus.rx_ready); end
    txq.delete();
    rxq.delete();
    ovf = 1'b0;
    unf = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    drive(DEV, SEL_NONE, 8'h77, 1'b0, 1'b0, 8'h00);
    step();
    drive(SEL_NONE, DEV, 8'h00, 1'b1, 1'b0, 8'h00);
    checks++; if (bus.tx_data !== 8'h77) begin errors++; $display("FAIL rst_new_first: got %h want 77", bus.tx_data); end
    checks++; if (bus.mainbus_out !== 8'h00) begin errors++; $display("FAIL rst_rx_discarded: got %h want 00", bus.mainbus_out); end
    step();
    drive(SEL_NONE, SEL_NONE, 8'h00, 1'b0, 1'b0, 8'h00);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_after_drain: got %b want 0", bus.tx_valid); end
    step();
  endtask

  function automatic logic [3:0] pick();
    case ($urandom_range(0, 3))
      0:       return DEV;
      1:       return ST;
      2:       return SEL_NONE;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(pick(), pick(), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), 8'($urandom));
      checks++; if (bus.tx_valid !== e_tx_valid()) begin errors++; $display("FAIL rand_tx_valid@%0d: got %b want %b", n, bus.tx_valid, e_tx_valid()); end
      checks++; if (bus.tx_data !== e_tx_data()) begin errors++; $display("FAIL rand_tx_data@%0d: got %h want %h", n, bus.tx_data, e_tx_data()); end
      checks++; if (bus.rx_ready !== e_rx_ready()) begin errors++; $display("FAIL rand_rx_ready@%0d: got %b want %b", n, bus.rx_ready, e_rx_ready()); end
      checks++; if (bus.mainbus_oe_n !== e_oe_n()) begin errors++; $display("FAIL rand_oe_n@%0d: got %b want %b", n, bus.mainbus_oe_n, e_oe_n()); end
      checks++; if (bus.mainbus_out !== e_out()) begin errors++; $display("FAIL rand_out@%0d: got %h want %h", n, bus.mainbus_out, e_out()); end
      step();
    end
  endtask

  initial begin
    bus.mainbus_load_select   = SEL_NONE;
    bus.mainbus_assert_select = SEL_NONE;
    bus.mainbus_in            = 8'h00;
    bus.tx_ready              = 1'b0;
    bus.rx_data               = 8'h00;
    bus.rx_valid              = 1'b0;
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx_read();
    test_rx_full();
    test_status();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mainbus_fifo_device.md
Name: mainbus_fifo_device

Overview:
- Main-bus peripheral that responds to the 4-bit assert/load select codes produced by the stage-2 control decoder. Sits in one of the device slots dev9..dev14.
- CPU side: loads push bytes into a TX FIFO; asserts pop bytes from an RX FIFO and drive them onto the main bus.
- External side: valid/ready byte streams (TX out, RX in). An optional status register occupies a second device slot.

Parameters:
- DEV_ID, 4'h9: select code for the data port; legal values 4'h9..4'hE.
- STATUS_ID, 4'hA: select code for the status port; must differ from DEV_ID; legal 4'h9..4'hE.
- DEPTH, 8: entries per FIFO; power of two, 2..256.
- WIDTH, 8: data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- mainbus_assert_select  in  4  registered assert code from the control decoder.
- mainbus_load_select  in  4  registered load code from the control decoder.
- mainbus_in  in  WIDTH  main bus value, sampled on posedge.
- mainbus_out  out  WIDTH  value driven when this device is asserting, else 0.
- mainbus_oe_n  out  1  active-low drive enable; 0 iff assert_select equals DEV_ID or STATUS_ID (status only when enabled).
- tx_data  out  WIDTH  head of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  external consumer accepts tx_data on posedge when tx_valid.
- rx_data  in  WIDTH  external byte.
- rx_valid  in  1  external byte offered.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- Select codes change on negedge clk. The device decodes combinationally and commits on the following posedge: half-cycle setup, one strobe per cycle.
- Reset, asynchronous: both FIFO pointers 0, sticky flags 0. Outputs: tx_valid=0, rx_ready=1, mainbus_oe_n=1, mainbus_out=0, tx_data=0.
- CPU write, load_select==DEV_ID:
  - Not full: push mainbus_in into TX at posedge.
  - TX full (state before the edge): byte dropped, tx_overflow set.
  - An external pop in the same cycle does not rescue the push.
- CPU read, assert_select==DEV_ID:
  - mainbus_out = RX head combinationally; pop at posedge if non-empty.
  - RX empty (state before the edge): mainbus_out=0, no pop, rx_underflow set.
  - An external push in the same cycle still lands.
- External TX handshake: pop when tx_valid && tx_ready at posedge.
- External RX handshake: push when rx_valid && rx_ready at posedge.
- Latency: a byte written at posedge k shows tx_valid=1 after edge k. A byte pushed externally at edge k is readable by the CPU in cycle k+1.
- Simultaneous push and pop on the same FIFO when neither full nor empty: both occur and the count is unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is MSB differs with the rest equal; empty is pointers equal.
- Load codes equal to STATUS_ID are ignored. Assert codes other than DEV_ID/STATUS_ID: mainbus_oe_n=1, mainbus_out=0.
- Reset mid-transfer: FIFO contents are discarded and outputs return to reset values immediately.

Optional Feature:
- Macro: MAINBUS_FIFO_STATUS_EN.
- Defined:
  - assert_select==STATUS_ID drives {tx_overflow, rx_underflow, 2'b00, tx_full, tx_empty, rx_full, rx_empty} for WIDTH=8; upper bits are zero-extended when WIDTH>8.
  - The status read clears both sticky flags at that posedge.
  - A sticky event in the same cycle as the read wins and the flag stays set.
- Undefined: there is no status register and no sticky flags, and STATUS_ID does nothing.

Decomposition:
- Shared package mainbus_pkg holds the select-code constants (SEL_NONE=0, SEL_A=1 ... SEL_ALU=8, SEL_DEV9..SEL_DEV14=9..14, SEL_MEM=15). The stage-2 decoder and all devices use the same constants.
- Sub-module sync_fifo (DEPTH, WIDTH; push/pop/full/empty/head), instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then CPU writes 0x11, 0x22, 0x33 with tx_ready=0 -> tx_valid=1 and tx_data=0x11. Raise tx_ready -> 0x11, 0x22, 0x33 on consecutive cycles, then tx_valid=0.
- Fill TX with 8 writes 0x00..0x07, then write 0xAA -> 0xAA dropped and tx_overflow=1. Draining yields exactly 0x00..0x07.
- External push 0x5C, CPU read next cycle -> mainbus_oe_n=0 and mainbus_out=0x5C. A second read -> mainbus_out=0x00 and rx_underflow=1.
- RX full (8 entries) with rx_valid=1 -> rx_ready=0 and no push. CPU read in the same cycle -> next cycle rx_ready=1 and count=7.
- With MAINBUS_FIFO_STATUS_EN, after overflow and underflow, status read -> bits 7 and 6 set. Second status read -> bits 7 and 6 clear.
- Assert reset asynchronously mid-stream with 3 entries in TX -> tx_valid=0 immediately. After release, a new write emerges first.
